// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers and the beat tag bundle for the pipelined adder tree.
// ADDER_TREE_SAT_EN (in pipe_adder_tree) selects saturating accumulation.
package adder_tree_pkg;

  typedef struct packed {
    logic valid;
    logic acc;
    logic last;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int levels(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  function automatic int stages(input int n, input int re);
    return (levels(n) + re - 1) / re;
  endfunction

  function automatic int width_at(input int iw, input int lvl);
    return iw + lvl;
  endfunction

  function automatic int count_at(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  // Level lvl (0-based) ends a register stage; the last level always does.
  function automatic bit reg_at(input int n, input int re,
                                input int lvl);
    return (((lvl + 1) % re) == 0) || (lvl == levels(n) - 1);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One pairwise-add level: N_IN operands of W bits -> ceil(N_IN/2) of W+1 bits.
// An odd trailing operand is paired with zero; output is registered or bypassed.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = 8,
  parameter bit REG  = 1'b1,
  localparam int NO  = (N_IN + 1) / 2,
  localparam int WO  = W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  tag_t              i_tag,
  input  logic [N_IN*W-1:0] i_data,
  output tag_t              o_tag,
  output logic [NO*WO-1:0]  o_data
);

  logic [NO*WO-1:0] w_sum;

  for (genvar j = 0; j < NO; j++) begin : g_pair
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    assign w_a = i_data[2*j*W +: W];
    if (2*j + 1 < N_IN) begin : g_b
      assign w_b = i_data[(2*j+1)*W +: W];
    end else begin : g_pad
      assign w_b = '0;
    end
    assign w_sum[j*WO +: WO] =
      {w_a[W-1], w_a} + {w_b[W-1], w_b};
  end

  if (REG) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_tag  <= '0;
        o_data <= '0;
      end else if (i_en) begin
        o_tag  <= i_tag;
        o_data <= w_sum;
      end
    end
  end else begin : g_byp
    logic w_unused;
    assign w_unused = ^{clk, rst_n, i_en};
    assign o_tag  = i_tag;
    assign o_data = w_sum;
  end

endmodule

// File: rtl/pipe_adder_tree.sv
// Pipelined signed adder tree with optional cross-beat accumulation.
// Define ADDER_TREE_SAT_EN for saturating accumulation; default wraps.
module pipe_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int N_IN      = 128,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH + clog2(N_IN) + 8,
  parameter int REG_EVERY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*IN_WIDTH-1:0] data_in,
  input  logic                     acc_mode,
  input  logic                     in_last,
  output logic [OUT_WIDTH-1:0]     sum_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat_flag
);

  localparam int LV = levels(N_IN);
  localparam int TW = width_at(IN_WIDTH, LV);

  logic                        w_en;
  tag_t                        w_tt;
  logic signed [TW-1:0]        w_tree;
  logic signed [OUT_WIDTH-1:0] w_ext;
  logic signed [OUT_WIDTH-1:0] w_base;
  logic signed [OUT_WIDTH-1:0] w_res;
  logic signed [OUT_WIDTH:0]   w_wide;
  logic                        w_sat;
  logic                        w_emit;

  logic signed [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0]        r_sum;
  logic                        r_valid;

`ifdef ADDER_TREE_SAT_EN
  localparam logic [OUT_WIDTH-1:0] S_MAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] S_MIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};
  logic w_ovf;
  logic r_sat;
  logic r_acc_sat;
`endif

  // One global enable: a full, unaccepted output freezes everything.
  assign in_ready = !out_valid || out_ready;
  assign w_en     = in_ready;

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int NI = count_at(N_IN, l);
    localparam int WI = width_at(IN_WIDTH, l);
    logic [NI*WI-1:0]             w_in;
    logic [((NI+1)/2)*(WI+1)-1:0] w_out;
    tag_t                         w_tin;
    tag_t                         w_tout;
    if (l == 0) begin : g_src
      assign w_in  = data_in;
      assign w_tin = '{valid: in_valid, acc: acc_mode,
                       last: in_last};
    end else begin : g_chain
      assign w_in  = g_lvl[l-1].w_out;
      assign w_tin = g_lvl[l-1].w_tout;
    end
    adder_tree_level #(
      .N_IN (NI),
      .W    (WI),
      .REG  (reg_at(N_IN, REG_EVERY, l))
    ) u_lvl (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_tag  (w_tin),
      .i_data (w_in),
      .o_tag  (w_tout),
      .o_data (w_out)
    );
  end

  assign w_tree = g_lvl[LV-1].w_out;
  assign w_tt   = g_lvl[LV-1].w_tout;
  assign w_ext  = OUT_WIDTH'(w_tree);
  assign w_emit = w_tt.valid && (!w_tt.acc || w_tt.last);

  // A non-accumulating beat starts from zero, dropping any partial sum.
  always_comb begin
    w_base = w_tt.acc ? r_acc : '0;
    w_wide = {w_base[OUT_WIDTH-1], w_base}
           + {w_ext[OUT_WIDTH-1], w_ext};
    w_res  = w_wide[OUT_WIDTH-1:0];
    w_sat  = 1'b0;
`ifdef ADDER_TREE_SAT_EN
    w_ovf  = w_wide[OUT_WIDTH] != w_wide[OUT_WIDTH-1];
    w_sat  = w_tt.acc && r_acc_sat;
    if (w_ovf) begin
      w_res = w_wide[OUT_WIDTH] ? S_MIN : S_MAX;
      w_sat = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else if (w_en) begin
      r_valid <= w_emit;
      if (w_tt.valid) begin
        r_acc <= w_emit ? '0 : w_res;
        if (w_emit) r_sum <= w_res;
      end
    end
  end

`ifdef ADDER_TREE_SAT_EN
  // Saturation inside a group is sticky until its result is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat     <= 1'b0;
      r_acc_sat <= 1'b0;
    end else if (w_en && w_tt.valid) begin
      r_acc_sat <= w_emit ? 1'b0 : w_sat;
      if (w_emit) r_sat <= w_sat;
    end
  end
  assign sat_flag = r_sat;
`else
  assign sat_flag = w_sat;
`endif

  assign sum_out   = r_sum;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Directed bench for pipe_adder_tree: three instances cover the default
// tree, a non-power-of-two tree and a narrow saturating/wrapping result.
module tb_pipe_adder_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instance A: N_IN=128, IN_WIDTH=32, OUT_WIDTH=47, REG_EVERY=1
  logic           a_iv, a_ir, a_acc, a_last, a_ov, a_or, a_sat, a_hs;
  logic [4095:0]  a_data;
  logic [46:0]    a_sum;
  longint         a_q[$];

  pipe_adder_tree u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .data_in(a_data), .acc_mode(a_acc), .in_last(a_last),
    .sum_out(a_sum), .out_valid(a_ov), .out_ready(a_or),
    .sat_flag(a_sat)
  );

  // Instance B: N_IN=5, IN_WIDTH=8, OUT_WIDTH=19, REG_EVERY=2
  logic           b_iv, b_ir, b_ov, b_or, b_sat, b_hs;
  logic [39:0]    b_data;
  logic [18:0]    b_sum;
  longint         b_q[$];

  pipe_adder_tree #(.N_IN(5), .IN_WIDTH(8), .REG_EVERY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .data_in(b_data), .acc_mode(1'b0), .in_last(1'b0),
    .sum_out(b_sum), .out_valid(b_ov), .out_ready(b_or),
    .sat_flag(b_sat)
  );

  // Instance C: N_IN=4, IN_WIDTH=8, OUT_WIDTH=16
  logic           c_iv, c_ir, c_acc, c_last, c_ov, c_or, c_sat, c_hs;
  logic [31:0]    c_data;
  logic [15:0]    c_sum;
  longint         c_q[$];
  longint         c_sq[$];

  pipe_adder_tree #(.N_IN(4), .IN_WIDTH(8), .OUT_WIDTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
    .data_in(c_data), .acc_mode(c_acc), .in_last(c_last),
    .sum_out(c_sum), .out_valid(c_ov), .out_ready(c_or),
    .sat_flag(c_sat)
  );

  always @(posedge clk) begin
    a_hs <= a_iv && a_ir;
    b_hs <= b_iv && b_ir;
    c_hs <= c_iv && c_ir;
    if (rst_n && a_ov && a_or) a_q.push_back($signed(a_sum));
    if (rst_n && b_ov && b_or) b_q.push_back($signed(b_sum));
    if (rst_n && c_ov && c_or) begin
      c_q.push_back($signed(c_sum));
      c_sq.push_back(longint'(c_sat));
    end
  end

  task automatic go_a;
    int n = 0;
    do begin @(negedge clk); n++; end while (!a_hs && n < 100);
    if (!a_hs) check("a_accept_timeout", a_hs, 1);
    a_iv = 1'b0;
  endtask

  task automatic go_b;
    int n = 0;
    do begin @(negedge clk); n++; end while (!b_hs && n < 100);
    if (!b_hs) check("b_accept_timeout", b_hs, 1);
    b_iv = 1'b0;
  endtask

  task automatic go_c;
    int n = 0;
    do begin @(negedge clk); n++; end while (!c_hs && n < 100);
    if (!c_hs) check("c_accept_timeout", c_hs, 1);
    c_iv = 1'b0;
  endtask

  task automatic send_a(input longint v, input bit acc, input bit last);
    a_data       = '0;
    a_data[31:0] = 32'(v);
    a_acc        = acc;
    a_last       = last;
    a_iv         = 1'b1;
    go_a();
  endtask

  function automatic logic [39:0] pk5(input int e0, input int e1,
                                      input int e2, input int e3,
                                      input int e4);
    return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  initial begin
    int     n;
    longint h;
    rst_n = 1'b0;
    a_iv = 0; a_acc = 0; a_last = 0; a_or = 1; a_data = '0;
    b_iv = 0; b_or = 1; b_data = '0;
    c_iv = 0; c_acc = 0; c_last = 0; c_or = 1; c_data = '0;
    tick(2);
    check("rst_out_valid", a_ov, 0);
    check("rst_sum", a_sum, 0);
    check("rst_sat", c_sat, 0);
    check("rst_in_ready", a_ir, 1);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_in_ready", a_ir, 1);

    // All-ones on 128 inputs: 8-cycle latency, sum 128
    for (int k = 0; k < 128; k++) a_data[k*32 +: 32] = 32'd1;
    a_acc = 0; a_last = 0; a_iv = 1;
    go_a();
    n = 1;
    while (!a_ov && n < 40) begin tick(1); n++; end
    check("lat128", n, 8);
    check("sum128_ones", $signed(a_sum), 128);
    tick(3);
    a_q.delete();

    // Back-to-back patterns exercising sign and bit growth
    for (int k = 0; k < 128; k++) a_data[k*32 +: 32] = 32'(k - 64);
    a_iv = 1; go_a();
    for (int k = 0; k < 128; k++) a_data[k*32 +: 32] = 32'h7fff_ffff;
    a_iv = 1; go_a();
    for (int k = 0; k < 128; k++) a_data[k*32 +: 32] = 32'h8000_0000;
    a_iv = 1; go_a();
    tick(12);
    check("pat_count", a_q.size(), 3);
    if (a_q.size() == 3) begin
      check("pat_ramp", a_q[0], -64);
      check("pat_max", a_q[1], 64'sd274877906816);
      check("pat_min", a_q[2], -64'sd274877906944);
    end
    a_q.delete();

    // Accumulate 100, -40, 5
    send_a(100, 1, 0);
    send_a(-40, 1, 0);
    send_a(5, 1, 1);
    tick(12);
    check("acc_count", a_q.size(), 1);
    if (a_q.size() > 0) check("acc_sum", a_q[0], 65);
    a_q.delete();

    // Bubbles inside a group
    send_a(3, 1, 0);
    tick(3);
    send_a(4, 1, 0);
    tick(2);
    send_a(-10, 1, 1);
    tick(12);
    check("bubble_count", a_q.size(), 1);
    if (a_q.size() > 0) check("bubble_sum", a_q[0], -3);
    a_q.delete();

    // One-beat group equals plain sum; mode change discards partial
    send_a(77, 1, 1);
    send_a(77, 0, 0);
    send_a(50, 1, 0);
    send_a(9, 0, 0);
    send_a(1, 1, 1);
    tick(12);
    check("mode_count", a_q.size(), 4);
    if (a_q.size() == 4) begin
      check("one_beat_grp", a_q[0], 77);
      check("one_beat_plain", a_q[1], 77);
      check("mode_discard", a_q[2], 9);
      check("restart_zero", a_q[3], 1);
    end
    a_q.delete();

    // Stall with out_ready low for 4 cycles
    a_or = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) send_a(10 * i, 0, 0);
      end
      begin
        int m = 0;
        while (!a_ov && m < 40) begin tick(1); m++; end
        h = $signed(a_sum);
        check("stall_first", h, 10);
        for (int i = 0; i < 4; i++) begin
          tick(1);
          check("stall_in_ready", a_ir, 0);
          check("stall_hold", $signed(a_sum), h);
        end
        a_or = 1'b1;
      end
    join
    tick(14);
    check("stall_count", a_q.size(), 5);
    for (int i = 0; i < a_q.size() && i < 5; i++)
      check("stall_order", a_q[i], 10 * (i + 1));
    a_q.delete();

    // Reset mid-group
    send_a(1000, 1, 0);
    send_a(2000, 1, 0);
    rst_n = 1'b0;
    tick(2);
    check("midrst_valid", a_ov, 0);
    check("midrst_in_ready", a_ir, 1);
    rst_n = 1'b1;
    tick(1);
    send_a(7, 1, 1);
    tick(12);
    check("midrst_count", a_q.size(), 1);
    if (a_q.size() > 0) check("midrst_sum", a_q[0], 7);
    a_q.delete();

    // N_IN=5 with zero padding
    b_data = pk5(-3, 7, 0, 2, -10);
    b_iv = 1; go_b();
    n = 1;
    while (!b_ov && n < 40) begin tick(1); n++; end
    check("lat5", n, 3);
    check("sum5", $signed(b_sum), -4);
    tick(3);
    b_q.delete();
    b_data = pk5(127, 127, 127, 127, 127); b_iv = 1; go_b();
    b_data = pk5(-128, -128, -128, -128, -128); b_iv = 1; go_b();
    b_data = pk5(0, 0, 0, 0, -10); b_iv = 1; go_b();
    tick(8);
    check("n5_count", b_q.size(), 3);
    if (b_q.size() == 3) begin
      check("n5_max", b_q[0], 635);
      check("n5_min", b_q[1], -640);
      check("n5_odd_pad", b_q[2], -10);
    end

    // 16-bit accumulator overflow: 65 beats of 4*127 = 33020
    c_data = {8'd127, 8'd127, 8'd127, 8'd127};
    for (int i = 0; i < 65; i++) begin
      c_acc = 1; c_last = (i == 64); c_iv = 1;
      go_c();
    end
    c_data = {8'd4, 8'd3, 8'd2, 8'd1};
    c_acc = 0; c_last = 0; c_iv = 1;
    go_c();
    tick(10);
    check("ovf_count", c_q.size(), 2);
    if (c_q.size() == 2) begin
`ifdef ADDER_TREE_SAT_EN
      check("ovf_sum", c_q[0], 32767);
      check("ovf_sat", c_sq[0], 1);
`else
      check("ovf_sum", c_q[0], -32516);
      check("ovf_sat", c_sq[0], 0);
`endif
      check("after_ovf_sum", c_q[1], 10);
      check("after_ovf_sat", c_sq[1], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
